// File: rtl/aes_round_sequencer_pkg.sv
// aes_round_sequencer_pkg: shared constants and FSM state encoding for the AES round sequencer
// Contents: AES_NR round count, AES_WAIT_MAX key-ready timeout, round-index and
//  timer widths, and the 3-bit state_t encoding shared with key schedule and datapath.
package aes_round_sequencer_pkg;
    localparam int AES_NR       = 10;
    localparam int AES_WAIT_MAX = 15;
    localparam int ROUND_W      = 4;
    localparam int TIMER_W      = 4;
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ_KEY  = 3'd1,
        S_WAIT_KEY = 3'd2,
        S_ROUND    = 3'd3,
        S_FINISH   = 3'd4
    } state_t;
endpackage

// File: rtl/aes_round_sequencer_wait_timer.sv
// aes_round_sequencer_wait_timer: loadable down-counter with clear and expired flag
// Ports: i_clk/i_rst (async active-high) clock/reset; i_clear forces zero;
//  i_load loads i_value; i_dec counts down toward zero; o_expired high at zero.
module aes_round_sequencer_wait_timer
    import aes_round_sequencer_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_load,
    input  logic               i_dec,
    input  logic [TIMER_W-1:0] i_value,
    output logic               o_expired
);
    logic [TIMER_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_value;
        else if (i_dec && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_expired = (r_cnt == '0);
endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: control FSM for one AES-128 encryption pass
// Ports: i_clk/i_rst (async active-high) clock/reset; i_start begins a pass from IDLE;
//  i_abort cancels a pass; i_key_ry requested key valid; o_key_en/o_sel_key key
//  request and round index; o_load_state plaintext load; o_round_en/o_first_round/
//  o_last_round round strobe and kind; o_busy pass active; o_done ciphertext ready;
//  o_error key-ready timeout.
module aes_round_sequencer
    import aes_round_sequencer_pkg::*;
#(
    parameter int NR       = AES_NR,
    parameter int WAIT_MAX = AES_WAIT_MAX
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic               i_key_ry,
    output logic               o_key_en,
    output logic [ROUND_W-1:0] o_sel_key,
    output logic               o_load_state,
    output logic               o_round_en,
    output logic               o_first_round,
    output logic               o_last_round,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_error
);
    state_t             r_state, w_next;
    logic [ROUND_W-1:0] r_round, w_round_nx;
    logic               w_expired, w_accept, w_timeout, w_done;
    logic               r_key_en, r_load, r_round_en, r_first, r_last, r_busy, r_done, r_error;
    logic [ROUND_W-1:0] r_sel;

    // Loaded with WAIT_MAX-1 so it reads zero on the WAIT_MAX-th waiting cycle.
    aes_round_sequencer_wait_timer u_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_clear   (r_state == S_IDLE),
        .i_load    (r_state == S_REQ_KEY),
        .i_dec     (r_state == S_WAIT_KEY && !i_key_ry),
        .i_value   (TIMER_W'(WAIT_MAX - 1)),
        .o_expired (w_expired)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_round    <= '0;
            r_key_en   <= 1'b0;
            r_sel      <= '0;
            r_load     <= 1'b0;
            r_round_en <= 1'b0;
            r_first    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_round    <= w_round_nx;
            r_key_en   <= (w_next == S_REQ_KEY);
            r_sel      <= (w_next != S_IDLE) ? w_round_nx : '0;
            r_load     <= w_accept;
            r_round_en <= (w_next == S_ROUND);
            r_first    <= (w_next == S_ROUND) && (w_round_nx == '0);
            r_last     <= (w_next == S_ROUND) && (w_round_nx == ROUND_W'(NR));
            r_busy     <= (w_next != S_IDLE);
            r_done     <= w_done;
            r_error    <= w_timeout;
        end
    end

    // Abort overrides every transition out of a non-IDLE state.
    always_comb begin
        w_next = S_IDLE;
        if (!(i_abort && r_state != S_IDLE)) begin
            case (r_state)
                S_IDLE:     w_next = w_accept ? S_REQ_KEY : S_IDLE;
                S_REQ_KEY:  w_next = S_WAIT_KEY;
                S_WAIT_KEY: w_next = i_key_ry ? S_ROUND : (w_expired ? S_IDLE : S_WAIT_KEY);
                S_ROUND:    w_next = (r_round == ROUND_W'(NR)) ? S_FINISH : S_REQ_KEY;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // Done and Error are registered on leaving their state, so a same-cycle abort suppresses them.
    always_comb begin
        w_accept   = (r_state == S_IDLE) && i_start && !i_abort;
        w_timeout  = (r_state == S_WAIT_KEY) && !i_key_ry && w_expired && !i_abort;
        w_done     = (r_state == S_FINISH) && !i_abort;
        w_round_nx = w_accept ? '0 :
                     (r_state == S_ROUND && w_next == S_REQ_KEY) ? r_round + 1'b1 : r_round;
    end

    assign o_key_en      = r_key_en;
    assign o_sel_key     = r_sel;
    assign o_load_state  = r_load;
    assign o_round_en    = r_round_en;
    assign o_first_round = r_first;
    assign o_last_round  = r_last;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_error       = r_error;
endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: directed self-checking bench for aes_round_sequencer
module tb_aes_round_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       key_ry;
    logic       key_en, load_state, round_en, first, last, busy, done, err;
    logic [3:0] sel_key;
    int         n_checks = 0;
    int         n_fail = 0;
    int         ry_mode = 0;
    int         since = 0;

    aes_round_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_key_ry      (key_ry),
        .o_key_en      (key_en),
        .o_sel_key     (sel_key),
        .o_load_state  (load_state),
        .o_round_en    (round_en),
        .o_first_round (first),
        .o_last_round  (last),
        .o_busy        (busy),
        .o_done        (done),
        .o_error       (err)
    );

    always #5 clk = ~clk;

    // Key schedule responder: 0 immediate, 1 three cycles later than immediate,
    // 2 never ready for round 4, 3 never ready.
    always @(posedge clk) since <= key_en ? 1 : (since < 100 ? since + 1 : since);
    assign key_ry = (ry_mode == 0) ? 1'b1 :
                    (ry_mode == 1) ? (since >= 4) :
                    (ry_mode == 2) ? (sel_key != 4'd4) : 1'b0;

    // Runs one pass from a Start pulse; n counts edges after the accept edge.
    task automatic run_pass(input int abort_n, input int restart_n,
                            output int done_n, output int done_cnt, output int err_n,
                            output int err_cnt, output int rounds, output bit seq_ok,
                            output bit load_ok, output int end_n);
        done_n = -1; done_cnt = 0; err_n = -1; err_cnt = 0;
        rounds = 0; seq_ok = 1'b1; end_n = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        load_ok = load_state;
        for (int n = 0; n < 200; n++) begin
            if (n > 0 && load_state) seq_ok = 1'b0;
            if (round_en) begin
                if (sel_key !== 4'(rounds) || first !== (rounds == 0) || last !== (rounds == 10))
                    seq_ok = 1'b0;
                rounds++;
            end else if (first || last) seq_ok = 1'b0;
            if (done) begin done_cnt++; if (done_n < 0) done_n = n; end
            if (err) begin err_cnt++; if (err_n < 0) err_n = n; end
            if (!busy) begin end_n = n; break; end
            abort = (n == abort_n);
            start = (n == restart_n);
            @(posedge clk); #1;
        end
        abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({key_en, sel_key, load_state, round_en, first, last, busy, done, err} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {key_en, sel_key, load_state, round_en, first, last, busy, done, err});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dn, dc, en, ec, r, e; bit ok, ld;
        ry_mode = 0;
        run_pass(-1, -1, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL basic_load: got %0d expected 1", ld); end
        n_checks++; if (r !== 11) begin n_fail++; $display("FAIL basic_rounds: got %0d expected 11", r); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_sequence: got %0d expected 1", ok); end
        n_checks++; if (dn !== 34) begin n_fail++; $display("FAIL basic_done_latency: got %0d expected 34", dn); end
        n_checks++; if (ec !== 0) begin n_fail++; $display("FAIL basic_error: got %0d expected 0", ec); end
        @(posedge clk); #1;
    endtask

    task automatic test_key_delay();
        int dn, dc, en, ec, r, e; bit ok, ld;
        ry_mode = 1;
        run_pass(-1, -1, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (r !== 11) begin n_fail++; $display("FAIL delay_rounds: got %0d expected 11", r); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL delay_sequence: got %0d expected 1", ok); end
        n_checks++; if (dn !== 67) begin n_fail++; $display("FAIL delay_done_latency: got %0d expected 67", dn); end
        n_checks++; if (ec !== 0) begin n_fail++; $display("FAIL delay_error: got %0d expected 0", ec); end
        ry_mode = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        int dn, dc, en, ec, r, e; bit ok, ld;
        ry_mode = 2;
        run_pass(-1, -1, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (en !== 28) begin n_fail++; $display("FAIL timeout_error_cycle: got %0d expected 28", en); end
        n_checks++; if (ec !== 1) begin n_fail++; $display("FAIL timeout_error_count: got %0d expected 1", ec); end
        n_checks++; if (e !== 28) begin n_fail++; $display("FAIL timeout_busy_drop: got %0d expected 28", e); end
        n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL timeout_done: got %0d expected 0", dc); end
        n_checks++; if (r !== 4) begin n_fail++; $display("FAIL timeout_rounds: got %0d expected 4", r); end
        ry_mode = 0;
        @(posedge clk); #1;
        run_pass(-1, -1, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (dn !== 34) begin n_fail++; $display("FAIL recover_done: got %0d expected 34", dn); end
        n_checks++; if (ok !== 1'b1 || r !== 11) begin n_fail++; $display("FAIL recover_sequence: got ok=%0d rounds=%0d expected ok=1 rounds=11", ok, r); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int dn, dc, en, ec, r, e; bit ok, ld;
        ry_mode = 0;
        run_pass(-1, 8, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL restart_done_count: got %0d expected 1", dc); end
        n_checks++; if (dn !== 34) begin n_fail++; $display("FAIL restart_done: got %0d expected 34", dn); end
        n_checks++; if (r !== 11) begin n_fail++; $display("FAIL restart_rounds: got %0d expected 11", r); end
        @(posedge clk); #1;
        run_pass(-1, -1, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (ld !== 1'b1) begin n_fail++; $display("FAIL second_load: got %0d expected 1", ld); end
        n_checks++; if (dn !== 34) begin n_fail++; $display("FAIL second_done: got %0d expected 34", dn); end
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        int dn, dc, en, ec, r, e; bit ok, ld;
        ry_mode = 0;
        run_pass(22, -1, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (e !== 23) begin n_fail++; $display("FAIL abort_wait_idle: got %0d expected 23", e); end
        n_checks++; if (dc !== 0 || ec !== 0) begin n_fail++; $display("FAIL abort_wait_pulses: got done=%0d err=%0d expected 0 0", dc, ec); end
        n_checks++; if (r !== 7) begin n_fail++; $display("FAIL abort_wait_rounds: got %0d expected 7", r); end
        @(posedge clk); #1;
        run_pass(33, -1, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL abort_finish_done: got %0d expected 0", dc); end
        n_checks++; if (ec !== 0) begin n_fail++; $display("FAIL abort_finish_error: got %0d expected 0", ec); end
        n_checks++; if (e !== 34) begin n_fail++; $display("FAIL abort_finish_idle: got %0d expected 34", e); end
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        n_checks++; if (busy !== 1'b0 || load_state !== 1'b0) begin n_fail++; $display("FAIL abort_start_idle: got busy=%0d load=%0d expected 0 0", busy, load_state); end
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int dn, dc, en, ec, r, e; bit ok, ld, hit;
        ry_mode = 0;
        hit = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (round_en && sel_key == 4'd5) begin hit = 1'b1; break; end
            @(posedge clk); #1;
        end
        n_checks++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_reach_round5: got %0d expected 1", hit); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({key_en, sel_key, load_state, round_en, first, last, busy, done, err} !== 12'd0) begin
            n_fail++;
            $display("FAIL rst_async_outputs: got %b expected 0",
                     {key_en, sel_key, load_state, round_en, first, last, busy, done, err});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got %0d expected 0", busy); end
        run_pass(-1, -1, dn, dc, en, ec, r, ok, ld, e);
        n_checks++; if (dn !== 34 || r !== 11) begin n_fail++; $display("FAIL rst_recover: got done=%0d rounds=%0d expected 34 11", dn, r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_key_delay();
        test_timeout();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
